pc_branch_unit: RTL
===================

// Module: pc_branch_unit
// PURPOSE
// - Fetch PC register with decode-stage branch prediction and execute-stage resolution/redirect.
// - Bimodal table of 2-bit saturating counters (BHT) predicts immediate branches at decode.
// - Execute resolves the condition and detects mispredicts; a mispredict flushes and redirects fetch.
// - Replaces purely combinational next-PC select in the fetch/execute loop of the pipelined CPU.
// PARAMETERS
// - WIDTH      16  PC/data width (even; PCs are halfword aligned).
// - IMM_W       9  branch immediate width; signed, counts halfwords.
// - BHT_DEPTH  16  counters in the BHT; power of 2, >=2; IDX_W = clog2(BHT_DEPTH).
// - RESET_PC    0  PC value loaded on reset.
// PORTS
// - clk              in   1      clock, rising edge.
// - rst              in   1      asynchronous reset, active-high.
// - stall            in   1      hold PC (hazard); overridden by an ex redirect.
// - pc               out  WIDTH  current fetch PC (registered).
// - pc_plus          out  WIDTH  pc + 2 (combinational).
// - dec_valid        in   1      decode slot holds a valid instruction.
// - dec_is_branch    in   1      decode instruction is a branch (B or BR).
// - dec_is_reg       in   1      decode branch is register form (BR).
// - dec_pc           in   WIDTH  PC of the decode instruction.
// - dec_imm          in   IMM_W  immediate of the decode instruction.
// - dec_pred_taken   out  1      prediction for decode branch; pipelined to ex by the datapath.
// - ex_valid         in   1      execute slot holds a valid instruction.
// - ex_is_branch     in   1      execute instruction is a branch.
// - ex_is_reg        in   1      execute branch is register form.
// - ex_pc            in   WIDTH  PC of the execute instruction.
// - ex_imm           in   IMM_W  immediate of the execute instruction.
// - ex_cond          in   3      condition code.
// - ex_flags         in   3      {Z,V,N}: bit0 N, bit1 V, bit2 Z.
// - ex_rd1           in   WIDTH  register target for BR.
// - ex_pred_taken    in   1      dec_pred_taken carried to execute.
// - ex_taken         out  1      resolved outcome (0 when not a valid branch).
// - ex_mispredict    out  1      ex_valid & ex_is_branch & (ex_taken != ex_pred_taken).
// - flush            out  1      squash fetch and decode slots this cycle (= ex_mispredict).
// - stat_branches    out  16     resolved-branch count (PC_BRANCH_STATS_EN only).
// - stat_mispredicts out  16     mispredict count (PC_BRANCH_STATS_EN only).
// BEHAVIOUR
// - Reset (async): pc=RESET_PC; every BHT counter = 2'b01 (weakly not-taken); stats = 0.
// - Immediate target = pc_x + 2 + (sext(imm) << 1), truncated to WIDTH (wraps modulo 2^WIDTH).
// - BR target = ex_rd1 with bit0 forced to 0.
// - Condition codes:
//   - 000 !Z
//   - 001 Z
//   - 010 !Z&!N
//   - 011 N
//   - 100 Z|(!Z&!N)
//   - 101 N|Z
//   - 110 V
//   - 111 always
// - ex_taken = ex_valid & ex_is_branch & cond_true.
// - Prediction (combinational): idx = dec_pc[IDX_W:1].
//   - dec_pred_taken = dec_valid & dec_is_branch & !dec_is_reg & bht[idx][1].
//   - BR is always predicted not-taken.
// - Next-PC priority, registered at clk:
//   1. ex_mispredict: pc <= ex_taken ? ex_target : ex_pc+2.
//   2. stall: pc holds.
//   3. dec_pred_taken: pc <= decode immediate target.
//   4. otherwise: pc <= pc+2.
// - Redirect latency: 1 cycle. flush is asserted in the same cycle as ex_mispredict.
// - BHT update at clk when ex_valid & ex_is_branch & !ex_is_reg, idx = ex_pc[IDX_W:1].
//   - Taken: +1, saturating at 3. Not taken: -1, saturating at 0.
//   - The update is applied even when stall=1.
// - Same-cycle read and write of the same index: decode sees the old value; no bypass.
// - ex_mispredict overrides a decode prediction issued in the same cycle (that decode instruction is flushed).
// - Reset mid-operation: all state returns to reset values immediately; outputs follow from the reset state.
// CONFIGURATION
// - PC_BRANCH_STATS_EN defined:
//   - stat_branches increments per resolved branch (ex_valid & ex_is_branch).
//   - stat_mispredicts increments per ex_mispredict.
//   - Both saturate at 16'hFFFF.
// - PC_BRANCH_STATS_EN undefined: both stat outputs are tied to 0 and no stat registers exist.
// STRUCTURE
// - pc_branch_pkg:
//   - condition-code localparams COND_NE .. COND_UNC.
//   - flag bit indices FLG_N=0, FLG_V=1, FLG_Z=2.
//   - counter constants CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3.
// - Sub-module branch_hist_table:
//   - one combinational read port, one synchronous write port, async reset.
//   - saturating update is done inside it.
// - Top level holds the PC register, adders, condition evaluation, next-PC mux and stats.
// TESTING
// - Reset: set rst=1 mid-run -> pc=0000 and dec_pred_taken=0 for any branch; stats=0.
// - Sequential fetch: no branches, stall=0 -> pc goes 0000,0002,0004. stall=1 at 0004 -> pc stays 0004.
// - Counter training: branch at ex_pc=0010, cond=111, imm=0x004, taken twice.
//   - decode of dec_pc=0010 then gives dec_pred_taken=1 and next pc=001A.
//   - Taken x4 more, then not-taken once -> prediction still 1 (saturation).
// - Mispredict: ex_pc=0020, cond=001, Z=1, pred=0, imm=0x1FE (-2).
//   - ex_mispredict=1 and flush=1 -> next pc=001E, even with stall=1.
// - BR form: ex_is_reg=1, ex_rd1=1235, cond=111 -> redirect to 1234; BHT unchanged.
// - Conflicts and stats: same-index read/write in one cycle -> decode sees the old value.
//   - Immediate-target wrap: pc=FFFE, imm=0x001 -> target 0002.
//   - With PC_BRANCH_STATS_EN: 3 branches, 1 mispredict -> stat_branches=3, stat_mispredicts=1.

Source files
------------

// File: rtl/pc_branch_pkg.sv
// Shared constants for the fetch PC / branch unit: condition codes, flag bit positions,
// bimodal counter states and the condition evaluator.
package pc_branch_pkg;

    localparam logic [2:0] COND_NE  = 3'b000;
    localparam logic [2:0] COND_EQ  = 3'b001;
    localparam logic [2:0] COND_GT  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b011;
    localparam logic [2:0] COND_GE  = 3'b100;
    localparam logic [2:0] COND_LE  = 3'b101;
    localparam logic [2:0] COND_VS  = 3'b110;
    localparam logic [2:0] COND_UNC = 3'b111;

    localparam int FLG_N = 0;
    localparam int FLG_V = 1;
    localparam int FLG_Z = 2;

    localparam logic [1:0] CNT_SNT = 2'd0;
    localparam logic [1:0] CNT_WNT = 2'd1;
    localparam logic [1:0] CNT_WT  = 2'd2;
    localparam logic [1:0] CNT_ST  = 2'd3;

    function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
        logic z, v, n, res;
        z = flags[FLG_Z];
        v = flags[FLG_V];
        n = flags[FLG_N];
        case (cond)
            COND_NE:  res = !z;
            COND_EQ:  res = z;
            COND_GT:  res = !z && !n;
            COND_LT:  res = n;
            COND_GE:  res = z || (!z && !n);
            COND_LE:  res = n || z;
            COND_VS:  res = v;
            default:  res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_hist_table.sv
// Bimodal branch history table: 2-bit saturating counters, one combinational read port
// and one synchronous saturating-update port.
module branch_hist_table
    import pc_branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr [DEPTH];

    // Reads return the pre-update value even when the same entry is written this cycle.
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[i] <= CNT_WNT;
            end
        end else if (wr_en) begin
            if (wr_taken) begin
                if (ctr[wr_idx] != CNT_ST) ctr[wr_idx] <= ctr[wr_idx] + 2'd1;
            end else begin
                if (ctr[wr_idx] != CNT_SNT) ctr[wr_idx] <= ctr[wr_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch PC register with decode-stage bimodal prediction and execute-stage redirect.
// Optional branch/mispredict counters are built when PC_BRANCH_STATS_EN is defined.
module pc_branch_unit
    import pc_branch_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               IMM_W     = 9,
    parameter int               BHT_DEPTH = 16,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    input  logic             dec_valid,
    input  logic             dec_is_branch,
    input  logic             dec_is_reg,
    input  logic [WIDTH-1:0] dec_pc,
    input  logic [IMM_W-1:0] dec_imm,
    output logic             dec_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_reg,
    input  logic [WIDTH-1:0] ex_pc,
    input  logic [IMM_W-1:0] ex_imm,
    input  logic [2:0]       ex_cond,
    input  logic [2:0]       ex_flags,
    input  logic [WIDTH-1:0] ex_rd1,
    input  logic             ex_pred_taken,
    output logic             ex_taken,
    output logic             ex_mispredict,
    output logic             flush,
    output logic [15:0]      stat_branches,
    output logic [15:0]      stat_mispredicts
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Immediates count halfwords and are relative to the following instruction.
    function automatic logic [WIDTH-1:0] imm_target(input logic [WIDTH-1:0] base,
                                                    input logic [IMM_W-1:0] imm);
        logic [WIDTH-1:0] ext;
        ext = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        return base + WIDTH'(2) + (ext << 1);
    endfunction

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] ex_target;
    logic [1:0]       dec_ctr;
    logic             bht_wr_en;

    assign bht_wr_en = ex_valid & ex_is_branch & ~ex_is_reg;

    branch_hist_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (dec_pc[IDX_W:1]),
        .rd_ctr   (dec_ctr),
        .wr_en    (bht_wr_en),
        .wr_idx   (ex_pc[IDX_W:1]),
        .wr_taken (ex_taken)
    );

    assign dec_pred_taken = dec_valid & dec_is_branch & ~dec_is_reg & dec_ctr[1];
    assign ex_taken       = ex_valid & ex_is_branch & cond_true(ex_cond, ex_flags);
    assign ex_mispredict  = ex_valid & ex_is_branch & (ex_taken != ex_pred_taken);
    assign flush          = ex_mispredict;
    assign ex_target      = ex_is_reg ? {ex_rd1[WIDTH-1:1], 1'b0} : imm_target(ex_pc, ex_imm);
    assign pc             = pc_q;
    assign pc_plus        = pc_q + WIDTH'(2);

    // A redirect from execute beats a stall, which beats a decode-stage prediction.
    always_comb begin
        pc_next = pc_plus;
        if (ex_mispredict) begin
            pc_next = ex_taken ? ex_target : ex_pc + WIDTH'(2);
        end else if (stall) begin
            pc_next = pc_q;
        end else if (dec_pred_taken) begin
            pc_next = imm_target(dec_pc, dec_imm);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_next;
    end

`ifdef PC_BRANCH_STATS_EN
    logic [15:0] br_cnt_q;
    logic [15:0] mis_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (ex_valid && ex_is_branch && br_cnt_q != 16'hFFFF) br_cnt_q <= br_cnt_q + 16'd1;
            if (ex_mispredict && mis_cnt_q != 16'hFFFF) mis_cnt_q <= mis_cnt_q + 16'd1;
        end
    end

    assign stat_branches    = br_cnt_q;
    assign stat_mispredicts = mis_cnt_q;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

    // The counter's low bit, the decode PC outside the index and the BR target's low bit are not needed.
    logic unused_bits;
    assign unused_bits = ^{dec_ctr[0], dec_pc, ex_rd1[0]};

endmodule
